// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM state type and
// default values for the LATENCY and DEPTH_WORDS parameters.
package dmem_pkg;

  localparam int LATENCY_DEFAULT     = 4;
  localparam int DEPTH_WORDS_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmemState_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage for the data memory responder. Writes happen on
// the rising edge when we_i is high; the read word is presented
// combinationally so the responder can capture it on the commit edge.
// Contents are never cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Store the committed write word; no reset so contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the pipeline MEM stage.
// A request is accepted in IDLE, waits LATENCY cycles, then completes with a
// one-cycle ack_o pulse in ACK. Writes commit and reads sample the array on
// the edge that enters ACK.
// Optional feature: define DMEM_ACCESS_CHECK_EN to flag misaligned or
// out-of-range accesses with err_o (write suppressed, read returns 0).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY     = LATENCY_DEFAULT,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dmemState_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        reqWe_q, reqWe_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqData_q, reqData_d;
  logic [31:0] rdData_q, rdData_d;
  logic        err_q, err_d;

  logic             commit;
  logic             commitWe;
  logic [31:0]      commitAddr;
  logic [31:0]      commitData;
  logic [IDX_W-1:0] commitIdx;
  logic             accErr;
  logic             arrWe;
  logic [31:0]      arrRdata;

`ifdef DMEM_ACCESS_CHECK_EN
  assign accErr = (commitAddr[1:0] != 2'b00) || (commitAddr[31:IDX_W+2] != '0);
`else
  logic unusedAddrBits;
  assign accErr         = 1'b0;
  assign unusedAddrBits = ^{commitAddr[31:IDX_W+2], commitAddr[1:0]};
`endif

  assign commitIdx = commitAddr[IDX_W+1:2];
  assign arrWe     = commit && commitWe && !accErr && !rst_i;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arrWe),
    .idx_i  (commitIdx),
    .wdata_i(commitData),
    .rdata_o(arrRdata)
  );

  // Commit straight from the inputs when LATENCY=1 commits on the accepting edge, else from the latched request
  always_comb begin
    if (state_q == IDLE) begin
      commitWe   = we_i;
      commitAddr = addr_i;
      commitData = data_i;
    end else begin
      commitWe   = reqWe_q;
      commitAddr = reqAddr_q;
      commitData = reqData_q;
    end
  end

  // Next-state, request latching, read/err capture and the handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reqWe_d   = reqWe_q;
    reqAddr_d = reqAddr_q;
    reqData_d = reqData_q;
    rdData_d  = rdData_q;
    err_d     = err_q;
    commit    = 1'b0;
    busy_o    = 1'b0;
    ack_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          busy_o    = 1'b1;
          reqWe_d   = we_i;
          reqAddr_d = addr_i;
          reqData_d = data_i;
          if (LATENCY == 1) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        ack_o   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (commit) begin
      err_d = accErr;
      if (!commitWe) begin
        rdData_d = accErr ? 32'd0 : arrRdata;
      end
    end
  end

  // Register FSM state and captured fields; reset clears everything except the array
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      reqWe_q   <= 1'b0;
      reqAddr_q <= 32'd0;
      reqData_q <= 32'd0;
      rdData_q  <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reqWe_q   <= reqWe_d;
      reqAddr_q <= reqAddr_d;
      reqData_q <= reqData_d;
      rdData_q  <= rdData_d;
      err_q     <= err_d;
    end
  end

  assign data_o = rdData_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two instances run side by side:
// index 0 uses LATENCY=4 / 256 words, index 1 uses LATENCY=1 / 16 words.
// A word-array model with per-word valid flags predicts ack timing, busy,
// err and read data. Honours DMEM_ACCESS_CHECK_EN when defined.
module tb_data_mem_responder;

  localparam int LAT0   = 4;
  localparam int DEPTH0 = 256;
  localparam int LAT1   = 1;
  localparam int DEPTH1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [1:0]  busy;
  logic [1:0]  err;
  logic [31:0] dout0, dout1;

  data_mem_responder #(.LATENCY(LAT0), .DEPTH_WORDS(DEPTH0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .data_i(wdata[0]),
    .ack_o(ack[0]), .data_o(dout0), .busy_o(busy[0]), .err_o(err[0])
  );

  data_mem_responder #(.LATENCY(LAT1), .DEPTH_WORDS(DEPTH1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .data_i(wdata[1]),
    .ack_o(ack[1]), .data_o(dout1), .busy_o(busy[1]), .err_o(err[1])
  );

  logic [31:0] modelMem   [2][DEPTH0];
  bit          modelValid [2][DEPTH0];
  logic [31:0] lastRead [2];
  bit          lastReadValid [2];

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int latOf(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] depthOf(input int d);
    return (d == 0) ? 32'(DEPTH0) : 32'(DEPTH1);
  endfunction

  function automatic logic [31:0] doutOf(input int d);
    return (d == 0) ? dout0 : dout1;
  endfunction

  function automatic bit accessErr(input int d, input logic [31:0] a);
    bit e;
    e = 1'b0;
`ifdef DMEM_ACCESS_CHECK_EN
    e = ((a % 4) != 0) || ((a / 4) >= depthOf(d));
`else
    e = e && (a == depthOf(d));
`endif
    return e;
  endfunction

  // One complete access: drive, predict, then check every cycle up to the idle cycle after ack
  task automatic applyStimulus(input int d, input bit w, input logic [31:0] a,
                               input logic [31:0] wd, input bit perturb, input bit keepReq);
    int          lat;
    int          idx;
    bit          e;
    logic [31:0] expData;
    bit          expKnown;
    lat = latOf(d);
    @(negedge clk);
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    #1;
    checkOutput($sformatf("d%0d busy accept a=%08h", d, a), 32'(busy[d]), 32'd1);
    idx = int'((a / 4) % depthOf(d));
    e   = accessErr(d, a);
    if (w) begin
      if (!e) begin
        modelMem[d][idx]   = wd;
        modelValid[d][idx] = 1'b1;
      end
      expData  = lastRead[d];
      expKnown = lastReadValid[d];
    end else begin
      if (e) begin
        expData  = 32'd0;
        expKnown = 1'b1;
      end else begin
        expData  = modelMem[d][idx];
        expKnown = modelValid[d][idx];
      end
      lastRead[d]      = expData;
      lastReadValid[d] = expKnown;
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("d%0d ack cyc%0d a=%08h", d, k, a), 32'(ack[d]), 32'(k == lat));
      if (k < lat) begin
        checkOutput($sformatf("d%0d busy cyc%0d", d, k), 32'(busy[d]), 32'd1);
        if (perturb) begin
          addr[d]  = $urandom;
          wdata[d] = $urandom;
          we[d]    = ~w;
        end
      end else begin
        checkOutput($sformatf("d%0d err a=%08h", d, a), 32'(err[d]), 32'(e));
        if (expKnown) checkOutput($sformatf("d%0d data a=%08h we=%0d", d, a, w), doutOf(d), expData);
      end
    end
    @(negedge clk);
    if (!keepReq) req[d] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput($sformatf("d%0d ack single", d), 32'(ack[d]), 32'd0);
    checkOutput($sformatf("d%0d busy idle", d), 32'(busy[d]), 32'(keepReq));
    if (expKnown) checkOutput($sformatf("d%0d data hold", d), doutOf(d), expData);
  endtask

  task automatic checkResetOutputs(input int d);
    checkOutput($sformatf("d%0d reset ack", d), 32'(ack[d]), 32'd0);
    checkOutput($sformatf("d%0d reset busy", d), 32'(busy[d]), 32'd0);
    checkOutput($sformatf("d%0d reset err", d), 32'(err[d]), 32'd0);
    checkOutput($sformatf("d%0d reset data", d), doutOf(d), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          wsel;
    int          mode;
    bit          w;
    bit          keep;
    logic [31:0] a;
    rst = 2'b11;
    req = 2'b00;
    we  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d]          = 32'd0;
      wdata[d]         = 32'd0;
      lastRead[d]      = 32'd0;
      lastReadValid[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs(0);
    checkResetOutputs(1);
    @(negedge clk);
    rst = 2'b00;

    // Basic write then read-back at LATENCY=4
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    // LATENCY=1: read after reset, then back-to-back with req held
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);

    // Upper address bits wrap (or are flagged when checking is enabled)
    applyStimulus(0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h13, 32'h5A5A0F0F, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);

    // Inputs changing during WAIT must not disturb the latched request
    applyStimulus(0, 1'b1, 32'h30, 32'h600DCAFE, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0);

    // Reset during WAIT aborts the write
    applyStimulus(0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs(0);
    @(negedge clk);
    rst[0] = 1'b0;
    lastRead[0] = 32'd0; lastReadValid[0] = 1'b1;
    for (int k = 0; k <= LAT0; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("d0 no ack after abort %0d", k), 32'(ack[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

    // Reset coincident with the commit edge blocks the write
    applyStimulus(0, 1'b1, 32'h24, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'h22222222;
    @(posedge clk);
    repeat (LAT0 - 2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs(0);
    @(negedge clk);
    rst[0] = 1'b0;
    lastRead[0] = 32'd0; lastReadValid[0] = 1'b1;
    applyStimulus(0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        w    = 1'($urandom_range(0, 1));
        wsel = (d == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, DEPTH1 - 1));
        mode = int'($urandom_range(0, 9));
        a    = 32'(wsel) * 4;
        if (mode == 7) a = a + 32'($urandom_range(1, 3));
        else if (mode == 8) a = a + depthOf(d) * 4 * 32'($urandom_range(1, 7));
        else if (mode == 9) a = $urandom;
        keep = ($urandom_range(0, 3) == 0);
        applyStimulus(d, w, a, $urandom, keep ? 1'b0 : 1'($urandom_range(0, 1)), keep);
      end
      @(negedge clk);
      req[d] = 1'b0;
      repeat (3) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
